// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: NREQ requesters onto two regfile write ports, round-robin with starvation forcing.
// Grant is combinational; load/r/in are registered (1 cycle); losers and stalled requesters hold until ready.
module regfile_wb_arbiter #(
    parameter int NREQ         = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0][1:0] req_reg,
    input  logic [NREQ-1:0][7:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 load1,
    output logic                 load2,
    output logic [1:0]           r1,
    output logic [1:0]           r2,
    output logic [7:0]           in1,
    output logic [7:0]           in2,
    output logic [3:0]           pending
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0][CW-1:0] wait_q, wait_d;
    logic                   load1_q, load2_q;
    logic [1:0]             r1_q, r2_q;
    logic [7:0]             in1_q, in2_q;

    logic                   force_vld, g1_vld, g2_vld;
    logic [PW-1:0]          force_idx, g1_idx, g2_idx, idx;

    // Forced requester takes port 1 first, then the round-robin scan fills the rest.
    always_comb begin
        force_vld = 1'b0;
        force_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && wait_q[i] == CW'(STARVE_LIMIT)) begin
                force_vld = 1'b1;
                force_idx = PW'(i);
            end
        end
        g1_vld = force_vld;
        g1_idx = force_idx;
        g2_vld = 1'b0;
        g2_idx = '0;
        idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[idx] && !(force_vld && idx == force_idx)) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = idx;
                end else if (!g2_vld && req_reg[idx] != req_reg[g1_idx]) begin
                    g2_vld = 1'b1;
                    g2_idx = idx;
                end
            end
        end
        if (stall || rst) begin
            g1_vld = 1'b0;
            g2_vld = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (g1_vld) req_ready[g1_idx] = 1'b1;
        if (g2_vld) req_ready[g2_idx] = 1'b1;
    end

    // Stall freezes the counters, but a dropped request still clears its own count.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            wait_d[i] = wait_q[i];
            if (!req_valid[i] || req_ready[i]) begin
                wait_d[i] = '0;
            end else if (!stall && wait_q[i] != CW'(STARVE_LIMIT)) begin
                wait_d[i] = wait_q[i] + CW'(1);
            end
        end
        rr_ptr_d = g1_vld ? PW'((int'(g1_idx) + 1) % NREQ) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wait_q   <= '0;
            load1_q  <= 1'b0;
            load2_q  <= 1'b0;
            r1_q     <= '0;
            r2_q     <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wait_q   <= wait_d;
            load1_q  <= g1_vld;
            load2_q  <= g2_vld;
            if (g1_vld) begin
                r1_q  <= req_reg[g1_idx];
                in1_q <= req_data[g1_idx];
            end
            if (g2_vld) begin
                r2_q  <= req_reg[g2_idx];
                in2_q <= req_data[g2_idx];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int k = 0; k < 4; k++) begin
            pending[k] = (load1_q && r1_q == 2'(k)) || (load2_q && r2_q == 2'(k));
        end
    end

    assign load1 = load1_q;
    assign load2 = load2_q;
    assign r1    = r1_q;
    assign r2    = r2_q;
    assign in1   = in1_q;
    assign in2   = in2_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of writeback requesters, legal range 2..4.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive waiting cycles before a requester is forced to highest priority.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 stall  input  1  when 1, no grants are issued this cycle.
REQ-006 req_valid  input  NREQ  per-requester write request.
REQ-007 req_reg  input  NREQx2 (tiny8_reg)  per-requester destination register.
REQ-008 req_data  input  NREQx8 (tiny8_word)  per-requester write data.
REQ-009 req_ready  output  NREQ  per-requester grant; combinational, asserted in the cycle the request is accepted.
REQ-010 load1, load2  output  1 each  regfile write-port enables; registered.
REQ-011 r1, r2  output  2 each (tiny8_reg)  regfile write-port register indices; registered.
REQ-012 in1, in2  output  8 each (tiny8_word)  regfile write-port data; registered.
REQ-013 pending  output  4  bit k = 1 when register k is being written this cycle (load1&r1==k or load2&r2==k).

Function
REQ-014 Transfer occurs on a rising edge when req_valid[i] & req_ready[i]; requester holds valid/reg/data stable until transfer.
REQ-015 req_ready[i] is never 1 when req_valid[i] is 0, and req_ready is all-zero when stall=1 or rst=1.
REQ-016 Arbitration order: forced requester (REQ-020) first if any, then remaining requesters scanned from rr_ptr upward modulo NREQ.
REQ-017 First eligible valid requester in order gets port 1; next valid requester whose req_reg differs from the port-1 register gets port 2; all others ready=0.
REQ-018 Never two grants to the same register in one cycle; a same-register loser waits.
REQ-019 Latency one cycle: a request accepted at edge N drives load/r/in during cycle N+1 and is written to the regfile at edge N+1; port-1 grant maps to load1/r1/in1, port-2 grant to load2/r2/in2.
REQ-020 Per-requester wait counter (saturating at STARVE_LIMIT) increments each cycle valid=1 and not granted, clears on grant or valid=0; a requester at STARVE_LIMIT is forced; if several, lowest index forced.
REQ-021 Stall cycles do not increment wait counters.
REQ-022 rr_ptr (width clog2(NREQ)) updates on any grant to (port-1 grantee index + 1) mod NREQ; unchanged otherwise.
REQ-023 load1/load2 deassert in any cycle following an edge with no corresponding grant; r/in retain last value when load is 0.
REQ-024 Only one valid requester: granted on port 1, load2 = 0 next cycle.
REQ-025 Requester deasserting valid without transfer is legal; its counter clears, no grant issued.

Reset
REQ-026 On rst assertion, immediately: load1=load2=0, r1=r2=0, in1=in2=0, pending=0, rr_ptr=0, all wait counters=0.
REQ-027 A write accepted in the cycle before reset assertion is dropped; requesters reissue after reset.
REQ-028 First grants possible in the first cycle with rst=0.

Verification
REQ-029 Reset, then req0 valid reg=2 data=0x5A -> ready0=1 same cycle; next cycle load1=1 r1=2 in1=0x5A, load2=0, pending=4'b0100.
REQ-030 req0 reg1 0x11, req1 reg3 0x22, req2 reg0 0x33 all valid, rr_ptr=0 -> ready=3'b011; next cycle load1/r1=1/in1=0x11, load2/r2=3/in2=0x22; rr_ptr=1; following cycle req2 granted on port 1.
REQ-031 All three requesters target reg 2 continuously -> exactly one grant per cycle, load2 never 1, grantees rotate 0,1,2,0.
REQ-032 req1 and req2 both target reg 0 while req0 keeps winning with differing data, STARVE_LIMIT=4 -> a waiting requester granted on port 1 within 5 cycles of first waiting.
REQ-033 stall=1 for 3 cycles with all valid -> ready=0, load1=load2=0 after first stalled cycle, counters unchanged; grants resume the cycle stall drops.
REQ-034 Assert rst asynchronously mid-cycle with load1=1 -> load1, load2, pending go to 0 immediately, no regfile write at next edge; rr_ptr=0 after release.
